// File: rtl/mem_channel_arbiter.sv
// mem_channel_arbiter
//   Sits between the per-core caches and global memory. Each of NUM_CHANNELS
//   channels runs its own small FSM and picks one requesting consumer at a
//   time in round-robin order. It forwards that request to memory and relays
//   the result back. Both sides use a 4-phase valid/ready handshake. Memory
//   may take any number of cycles to answer.
//
// Ports
//   clk, reset                  clock (rising edge), synchronous active-high reset
//   consumer_read_valid/_address        per-consumer read requests (held until ready)
//   consumer_read_ready/_data           read completion; data is 0 while ready is 0
//   consumer_write_valid/_address/_data per-consumer write requests
//   consumer_write_ready                write completion (held until valid drops)
//   mem_read_valid/_address     per-channel memory read request
//   mem_read_ready/_data        per-channel memory read response
//   mem_write_valid/_address/_data  per-channel memory write request
//   mem_write_ready             per-channel memory write accept
module mem_channel_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } chan_state_t;

    chan_state_t          state_reg   [NUM_CHANNELS];
    chan_state_t          state_next  [NUM_CHANNELS];
    logic [CW-1:0]        owner_reg   [NUM_CHANNELS];
    logic [CW-1:0]        owner_next  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] addr_reg    [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] addr_next   [NUM_CHANNELS];
    logic [DATA_BITS-1:0] wdata_reg   [NUM_CHANNELS];
    logic [DATA_BITS-1:0] wdata_next  [NUM_CHANNELS];
    logic [DATA_BITS-1:0] rdata_reg   [NUM_CHANNELS];
    logic [DATA_BITS-1:0] rdata_next  [NUM_CHANNELS];
    // Set once the owning consumer withdraws its request mid-transaction;
    // the memory access still finishes but the result is thrown away.
    logic                 dropped_reg [NUM_CHANNELS];
    logic                 dropped_next[NUM_CHANNELS];

    logic [NUM_CONSUMERS-1:0] busy_reg, busy_next;
    logic [CW-1:0]            rr_ptr_reg, rr_ptr_next;

    logic [NUM_CONSUMERS-1:0] write_req;
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    int                       idx;

    // A read-only instance never sees write requests, so write states are unreachable.
    assign write_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg   <= '0;
            rr_ptr_reg <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_reg[c]   <= IDLE;
                owner_reg[c]   <= '0;
                addr_reg[c]    <= '0;
                wdata_reg[c]   <= '0;
                rdata_reg[c]   <= '0;
                dropped_reg[c] <= 1'b0;
            end
        end else begin
            busy_reg   <= busy_next;
            rr_ptr_reg <= rr_ptr_next;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_reg[c]   <= state_next[c];
                owner_reg[c]   <= owner_next[c];
                addr_reg[c]    <= addr_next[c];
                wdata_reg[c]   <= wdata_next[c];
                rdata_reg[c]   <= rdata_next[c];
                dropped_reg[c] <= dropped_next[c];
            end
        end
    end

    // Channels are evaluated in index order; 'taken' accumulates grants so a
    // consumer picked by a lower channel is invisible to higher ones. The last
    // granting channel in the loop leaves its winner+1 in rr_ptr_next.
    always_comb begin
        taken       = busy_reg;
        busy_next   = busy_reg;
        rr_ptr_next = rr_ptr_reg;
        found       = 1'b0;
        idx         = 0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_next[c]   = state_reg[c];
            owner_next[c]   = owner_reg[c];
            addr_next[c]    = addr_reg[c];
            wdata_next[c]   = wdata_reg[c];
            rdata_next[c]   = rdata_reg[c];
            dropped_next[c] = dropped_reg[c];
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state_reg[c])
                IDLE: begin
                    found = 1'b0;
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        idx = (int'(rr_ptr_reg) + i) % NUM_CONSUMERS;
                        if (!found && !taken[idx] &&
                            (consumer_read_valid[idx] || write_req[idx])) begin
                            found           = 1'b1;
                            taken[idx]      = 1'b1;
                            busy_next[idx]  = 1'b1;
                            owner_next[c]   = CW'(idx);
                            dropped_next[c] = 1'b0;
                            rr_ptr_next     = CW'((idx + 1) % NUM_CONSUMERS);
                            // Read wins over write for the same consumer.
                            if (consumer_read_valid[idx]) begin
                                state_next[c] = READ_WAITING;
                                addr_next[c]  = consumer_read_address[idx*ADDR_BITS +: ADDR_BITS];
                            end else begin
                                state_next[c] = WRITE_WAITING;
                                addr_next[c]  = consumer_write_address[idx*ADDR_BITS +: ADDR_BITS];
                                wdata_next[c] = consumer_write_data[idx*DATA_BITS +: DATA_BITS];
                            end
                        end
                    end
                end
                READ_WAITING: begin
                    dropped_next[c] = dropped_reg[c] | ~consumer_read_valid[owner_reg[c]];
                    if (mem_read_ready[c]) begin
                        if (dropped_reg[c] || !consumer_read_valid[owner_reg[c]]) begin
                            state_next[c]           = IDLE;
                            busy_next[owner_reg[c]] = 1'b0;
                        end else begin
                            state_next[c] = READ_RELAYING;
                            rdata_next[c] = mem_read_data[c*DATA_BITS +: DATA_BITS];
                        end
                    end
                end
                WRITE_WAITING: begin
                    dropped_next[c] = dropped_reg[c] | ~write_req[owner_reg[c]];
                    if (mem_write_ready[c]) begin
                        if (dropped_reg[c] || !write_req[owner_reg[c]]) begin
                            state_next[c]           = IDLE;
                            busy_next[owner_reg[c]] = 1'b0;
                        end else begin
                            state_next[c] = WRITE_RELAYING;
                        end
                    end
                end
                READ_RELAYING: begin
                    if (!consumer_read_valid[owner_reg[c]]) begin
                        state_next[c]           = IDLE;
                        busy_next[owner_reg[c]] = 1'b0;
                    end
                end
                WRITE_RELAYING: begin
                    if (!write_req[owner_reg[c]]) begin
                        state_next[c]           = IDLE;
                        busy_next[owner_reg[c]] = 1'b0;
                    end
                end
                default: state_next[c] = IDLE;
            endcase
        end
    end

    // Memory-side outputs come straight from channel state; address/data are
    // zeroed outside the request window so everything reads 0 after reset.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            assign mem_read_valid[gi] = (state_reg[gi] == READ_WAITING);
            assign mem_read_address[gi*ADDR_BITS +: ADDR_BITS] =
                (state_reg[gi] == READ_WAITING) ? addr_reg[gi] : '0;
            assign mem_write_valid[gi] = (WRITE_ENABLE != 0) && (state_reg[gi] == WRITE_WAITING);
            assign mem_write_address[gi*ADDR_BITS +: ADDR_BITS] =
                mem_write_valid[gi] ? addr_reg[gi] : '0;
            assign mem_write_data[gi*DATA_BITS +: DATA_BITS] =
                mem_write_valid[gi] ? wdata_reg[gi] : '0;
        end

        for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_cons
            logic                 rd_ready;
            logic                 wr_ready;
            logic [DATA_BITS-1:0] rd_data;
            always_comb begin
                rd_ready = 1'b0;
                wr_ready = 1'b0;
                rd_data  = '0;
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    if (owner_reg[c] == CW'(gi)) begin
                        if (state_reg[c] == READ_RELAYING) begin
                            rd_ready = 1'b1;
                            rd_data  = rdata_reg[c];
                        end
                        if (state_reg[c] == WRITE_RELAYING) begin
                            wr_ready = 1'b1;
                        end
                    end
                end
            end
            assign consumer_read_ready[gi]                      = rd_ready;
            assign consumer_read_data[gi*DATA_BITS +: DATA_BITS] = rd_data;
            assign consumer_write_ready[gi]                     = (WRITE_ENABLE != 0) && wr_ready;
        end
    endgenerate

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// tb_mem_channel_arbiter
//   Directed bench for mem_channel_arbiter. dut1 is the single-channel
//   instance served by a behavioural memory with programmable latency;
//   dut2 is a two-channel instance whose memory side is driven by hand.
`timescale 1ns/1ps
module tb_mem_channel_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    // dut1: 1 channel
    logic [3:0]  c_rv = '0, c_wv = '0;
    logic [3:0]  c_rr, c_wr;
    logic [31:0] c_ra = '0, c_wa = '0, c_wd = '0;
    logic [31:0] c_rd;
    logic [0:0]  m_rv, m_wv;
    logic [0:0]  m_rr = '0, m_wr = '0;
    logic [7:0]  m_ra, m_wa, m_wd;
    logic [7:0]  m_rdat = '0;

    // dut2: 2 channels
    logic [3:0]  d_rv = '0, d_wv = '0;
    logic [3:0]  d_rr, d_wr;
    logic [31:0] d_ra = '0, d_wa = '0, d_wd = '0;
    logic [31:0] d_rd;
    logic [1:0]  d_mrv, d_mwv;
    logic [1:0]  d_mrr = '0, d_mwr = '0;
    logic [15:0] d_mra, d_mwa, d_mwd;
    logic [15:0] d_mrdat = '0;

    mem_channel_arbiter #(.NUM_CHANNELS(1)) dut1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
        .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
        .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
        .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
        .mem_read_valid(m_rv), .mem_read_address(m_ra),
        .mem_read_ready(m_rr), .mem_read_data(m_rdat),
        .mem_write_valid(m_wv), .mem_write_address(m_wa),
        .mem_write_data(m_wd), .mem_write_ready(m_wr)
    );

    mem_channel_arbiter #(.NUM_CHANNELS(2)) dut2 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(d_rv), .consumer_read_address(d_ra),
        .consumer_read_ready(d_rr), .consumer_read_data(d_rd),
        .consumer_write_valid(d_wv), .consumer_write_address(d_wa),
        .consumer_write_data(d_wd), .consumer_write_ready(d_wr),
        .mem_read_valid(d_mrv), .mem_read_address(d_mra),
        .mem_read_ready(d_mrr), .mem_read_data(d_mrdat),
        .mem_write_valid(d_mwv), .mem_write_address(d_mwa),
        .mem_write_data(d_mwd), .mem_write_ready(d_mwr)
    );

    // Behavioural memory for dut1: fixed read contents, one-cycle ready pulse
    // after the programmed number of waiting cycles.
    int rd_lat = 0, wr_lat = 0, rd_cnt = 0, wr_cnt = 0, rd_done = 0, wr_done = 0;
    logic [7:0] last_wa = '0, last_wd = '0;

    function automatic logic [7:0] rom(input logic [7:0] a);
        return (a == 8'h3C) ? 8'hA5 : (a ^ 8'hFF);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            m_rr = '0; m_wr = '0; rd_cnt = 0; wr_cnt = 0;
        end else begin
            if (m_rr[0]) m_rr = '0;
            else if (m_rv[0]) begin
                if (rd_cnt >= rd_lat) begin
                    m_rr = 1'b1; m_rdat = rom(m_ra); rd_cnt = 0; rd_done++;
                end else rd_cnt++;
            end
            if (m_wr[0]) m_wr = '0;
            else if (m_wv[0]) begin
                if (wr_cnt >= wr_lat) begin
                    m_wr = 1'b1; last_wa = m_wa; last_wd = m_wd; wr_cnt = 0; wr_done++;
                end else wr_cnt++;
            end
        end
    end

    int vectors = 0, miscompares = 0;
    bit agent_en = 1'b0;
    logic [3:0] rearm = '0, pend = '0;
    int served[$];
    int sdata[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; afterwards optionally play the dut1 consumers: take the
    // result, drop valid, and re-request once if armed.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (agent_en) begin
            for (int k = 0; k < 4; k++) begin
                if (c_rr[k] && c_rv[k]) begin
                    c_rv[k] = 1'b0;
                    served.push_back(k);
                    sdata.push_back(int'(c_rd[k*8 +: 8]));
                    if (rearm[k]) begin rearm[k] = 1'b0; pend[k] = 1'b1; end
                end else if (pend[k] && !c_rr[k]) begin
                    pend[k] = 1'b0; c_rv[k] = 1'b1;
                end
                if (c_wr[k] && c_wv[k]) begin
                    c_wv[k] = 1'b0;
                    served.push_back(16 + k);
                    sdata.push_back(0);
                end
            end
        end
    endtask

    task automatic wait_served(input int n, input int budget);
        int cyc = 0;
        while (served.size() < n && cyc < budget) begin step(); cyc++; end
        chk("served_count", 32'(served.size()), 32'(n));
    endtask

    task automatic wait_rready(input int k, input int budget);
        int cyc = 0;
        while (!c_rr[k] && cyc < budget) begin step(); cyc++; end
        chk("wait_read_ready", 32'(c_rr[k]), 32'd1);
    endtask

    function automatic int qs(input int i);
        return (i < served.size()) ? served[i] : -1;
    endfunction

    function automatic int qd(input int i);
        return (i < sdata.size()) ? sdata[i] : -1;
    endfunction

    initial begin
        int base;
        bit seen;
        // reset state
        step(); step();
        chk("rst_c_rready", 32'(c_rr), 0);
        chk("rst_c_wready", 32'(c_wr), 0);
        chk("rst_c_rdata", c_rd, 0);
        chk("rst_m_valid", {30'd0, m_rv, m_wv}, 0);
        chk("rst_d2_valid", {28'd0, d_mrv, d_mwv}, 0);
        reset = 1'b0;
        step();

        // consumer 2 reads 0x3C, slow memory
        rd_lat = 2;
        c_ra[23:16] = 8'h3C; c_rv[2] = 1'b1;
        step();
        chk("t1_mem_valid", 32'(m_rv), 1);
        chk("t1_mem_addr", 32'(m_ra), 32'h3C);
        chk("t1_no_ready_yet", 32'(c_rr), 0);
        wait_rready(2, 20);
        chk("t1_ready", 32'(c_rr), 32'b0100);
        chk("t1_data", c_rd, 32'h00A5_0000);
        chk("t1_mem_valid_dropped", 32'(m_rv), 0);
        step(); step();
        chk("t1_hold_ready", 32'(c_rr), 32'b0100);
        chk("t1_hold_data", c_rd, 32'h00A5_0000);
        c_rv[2] = 1'b0;
        step();
        chk("t1_release_ready", 32'(c_rr), 0);
        chk("t1_release_data", c_rd, 0);

        // two channels, four simultaneous reads
        d_ra = 32'h8382_8180; d_rv = 4'hF;
        step();
        chk("t3_both_valid", 32'(d_mrv), 32'b11);
        chk("t3_ch0_addr", 32'(d_mra[7:0]), 32'h80);
        chk("t3_ch1_addr", 32'(d_mra[15:8]), 32'h81);
        d_mrdat = 16'hB1B0; d_mrr = 2'b11;
        step();
        d_mrr = 2'b00;
        chk("t3_ready", 32'(d_rr), 32'b0011);
        chk("t3_data", d_rd, 32'h0000_B1B0);
        chk("t3_valid_dropped", 32'(d_mrv), 0);
        d_rv = 4'b1100;
        step(); step();
        chk("t3_second_valid", 32'(d_mrv), 32'b11);
        chk("t3_second_addr", 32'(d_mra), 32'h8382);
        d_mrdat = 16'hB3B2; d_mrr = 2'b11;
        step();
        d_mrr = 2'b00;
        chk("t3_second_ready", 32'(d_rr), 32'b1100);
        chk("t3_second_data", d_rd, 32'hB3B2_0000);
        d_rv = 4'b0000;
        step(); step();

        // consumers 0,1,3 read at once after reset; 0 re-requests when served
        reset = 1'b1; step(); step(); reset = 1'b0;
        rd_lat = 0;
        served.delete(); sdata.delete();
        agent_en = 1'b1; rearm = 4'b0001;
        c_ra = 32'h4300_4140; c_rv = 4'b1011;
        wait_served(4, 60);
        chk("t2_order0", 32'(qs(0)), 0);
        chk("t2_order1", 32'(qs(1)), 1);
        chk("t2_order2", 32'(qs(2)), 3);
        chk("t2_order3", 32'(qs(3)), 0);
        chk("t2_data0", 32'(qd(0)), 32'hBF);
        chk("t2_data1", 32'(qd(1)), 32'hBE);
        chk("t2_data2", 32'(qd(2)), 32'hBC);
        chk("t2_data3", 32'(qd(3)), 32'hBF);

        // consumer 1 reads and writes 0x10 together
        served.delete(); sdata.delete();
        wr_lat = 0; base = wr_done;
        c_ra[15:8] = 8'h10; c_wa[15:8] = 8'h10; c_wd[15:8] = 8'h5A;
        c_rv[1] = 1'b1; c_wv[1] = 1'b1;
        wait_served(2, 60);
        chk("t4_first_is_read", 32'(qs(0)), 1);
        chk("t4_read_data", 32'(qd(0)), 32'hEF);
        chk("t4_second_is_write", 32'(qs(1)), 17);
        chk("t4_write_addr", 32'(last_wa), 32'h10);
        chk("t4_write_data", 32'(last_wd), 32'h5A);
        chk("t4_write_count", 32'(wr_done - base), 1);
        step();

        // reset during WRITE_WAITING
        agent_en = 1'b0;
        wr_lat = 20; base = wr_done;
        c_wa[31:24] = 8'h20; c_wd[31:24] = 8'h99; c_wv[3] = 1'b1;
        step(); step();
        chk("t5_waiting_valid", 32'(m_wv), 1);
        chk("t5_waiting_addr", 32'(m_wa), 32'h20);
        chk("t5_waiting_data", 32'(m_wd), 32'h99);
        reset = 1'b1; c_wv = '0;
        step();
        chk("t5_rst_mem_valid", {30'd0, m_rv, m_wv}, 0);
        chk("t5_rst_cons_ready", {24'd0, c_rr, c_wr}, 0);
        reset = 1'b0;
        step();
        chk("t5_no_write_done", 32'(wr_done - base), 0);
        c_ra[15:8] = 8'h22; c_rv[1] = 1'b1;
        step();
        chk("t5_idle_grant", 32'(m_rv), 1);
        chk("t5_idle_addr", 32'(m_ra), 32'h22);
        step();
        chk("t5_read_ready", 32'(c_rr), 32'b0010);
        chk("t5_read_data", c_rd, 32'h0000_DD00);
        c_rv[1] = 1'b0;
        step();

        // consumer drops read_valid while WAITING
        rd_lat = 3; base = rd_done;
        c_ra[23:16] = 8'h3C; c_rv[2] = 1'b1;
        step();
        chk("t6_mem_valid", 32'(m_rv), 1);
        c_rv[2] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (c_rr != 4'b0000) seen = 1'b1;
        end
        chk("t6_never_ready", 32'(seen), 0);
        chk("t6_mem_completed", 32'(rd_done - base), 1);
        chk("t6_mem_idle", 32'(m_rv), 0);
        c_rv[2] = 1'b1;
        wait_rready(2, 20);
        chk("t6_retry_data", c_rd, 32'h00A5_0000);
        c_rv[2] = 1'b0;
        step();
        chk("t6_retry_release", 32'(c_rr), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
